neuron_sequencer: RTL and testbench
===================================

Name: neuron_sequencer

Overview:
- Per-neuron controller that sequences one neuron evaluation end to end.
- Accepts NUM_INPUTS signed input/weight pairs over a valid/ready stream and accumulates their products.
- Adds a bias, then drives the external combinational activation block (a_in / ready_signal / out) for one cycle and latches its 8-bit output.
- Sits between the layer input buffer and the layer output register file.

Parameters:
- WIDTH, 32, accumulator width; must match the activation block WIDTH.
- NUM_INPUTS, 62, number of input/weight pairs per neuron; must be ≥1.
- CNT_W, 8, counter width; requires 2^CNT_W ≥ NUM_INPUTS.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begins an evaluation; sampled only in IDLE.
- x_in  input  8  signed input activation.
- w_in  input  8  signed weight.
- in_valid  input  1  the x_in/w_in pair is valid.
- in_ready  output  1  sequencer accepts a pair this cycle.
- bias  input  WIDTH  signed bias; sampled in the BIAS state.
- acc_out  output  WIDTH  accumulator value; drives activation a_in.
- act_ready  output  1  drives activation ready_signal.
- act_in  input  8  activation block out.
- result  output  8  latched neuron output.
- done  output  1  one-cycle pulse when result is updated.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE, acc=0, cnt=0, result=0, done=0, in_ready=0, act_ready=0, busy=0.
- States: IDLE, ACCUM, BIAS, ACT, DONE. All outputs except acc_out and result are decoded from the state. acc_out is the accumulator register.
- IDLE:
  - start=1 at an edge: acc<=0, cnt<=0, go to ACCUM.
  - result holds its previous value.
- ACCUM:
  - in_ready=1.
  - Each in_valid&&in_ready edge: acc <= acc + sign_extend_WIDTH(x_in*w_in), where the product is a 16-bit signed product. cnt<=cnt+1.
  - On the handshake where cnt==NUM_INPUTS-1: go to BIAS.
  - in_valid low: acc and cnt hold; no timeout.
- BIAS: in_ready=0; acc<=acc+bias; go to ACT.
- ACT: act_ready=1 for exactly this cycle, with acc_out stable; result<=act_in at the closing edge; go to DONE.
- DONE: done=1 for one cycle; go to IDLE. The next start can be accepted in the following IDLE cycle.
- Arithmetic: all sums are two's-complement modulo 2^WIDTH, with no saturation in the sequencer. Clamping/ReLU comes only from the activation block.
- start while busy=1 (including the DONE cycle) is ignored and not queued.
- Latency, with start sampled at edge E0 and continuous in_valid:
  - Pairs are accepted at E1..EN.
  - BIAS follows EN.
  - ACT follows EN+1.
  - done is high in the cycle after EN+2.
  - Each in_valid gap cycle adds one cycle.
- NUM_INPUTS=1: ACCUM lasts one handshake, then BIAS.
- Reset mid-operation: abort immediately to the reset values above. The partial accumulation is discarded and result is cleared to 0.

Test Plan:
- Bench uses NUM_INPUTS=4 and the real activation block.
- Sum: x={1,2,3,4}, w={1,1,1,1}, bias=0, continuous valid -> acc_out=10 in ACT; result=8'd10; done exactly 6 cycles after the start edge; done high for 1 cycle.
- Negative: x={-10,-10,-10,-10}, w=1, bias=0 -> acc_out=-40 (0xFFFFFFD8) in ACT; result=0.
- Saturation: x=100, w=100 for all four pairs, bias=5 -> acc_out=40005; result=8'h7F.
- Backpressure: repeat the Sum case with in_valid low on alternate cycles (3 gaps) -> result=10; done 3 cycles later than in the Sum case; acc unchanged during gaps.
- Start while busy and bias: sum=10, bias=-10, start held high throughout -> acc_out=0; result=0.
  - Second evaluation begins only after the done cycle, i.e. in the next IDLE.
- Reset mid-op: assert rst after 2 handshakes -> immediately state=IDLE, in_ready=0, busy=0, result=0. A fresh Sum run then gives result=10.

Source files
------------

// File: rtl/neuron_sequencer.sv
// Sequences one neuron evaluation: a multiply-accumulate over NUM_INPUTS signed
// input/weight pairs, a bias add, then one cycle presenting the sum to an
// external combinational activation block whose output is latched.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             begin an evaluation (only honoured in IDLE)
//   x_in, w_in        signed 8-bit input/weight pair
//   in_valid/in_ready pair handshake (in_ready high while accumulating)
//   bias              signed WIDTH-bit bias, added in the BIAS state
//   acc_out           accumulator register, feeds activation a_in
//   act_ready         activation ready_signal, high for the single ACT cycle
//   act_in            activation block output
//   result            latched neuron output
//   done              one-cycle pulse after result updates
//   busy              high whenever not IDLE
module neuron_sequencer #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NUM_INPUTS = 62,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       x_in,
  input  logic [7:0]       w_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] bias,
  output logic [WIDTH-1:0] acc_out,
  output logic             act_ready,
  input  logic [7:0]       act_in,
  output logic [7:0]       result,
  output logic             done,
  output logic             busy
);

  localparam int unsigned PROD_W = 16;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_INPUTS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_BIAS,
    S_ACT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]         cnt;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [WIDTH-1:0]  prod_ext_c;
  logic                     accept_c;

  // Signed 8x8 product, sign-extended to the accumulator width
  assign prod_c     = $signed(x_in) * $signed(w_in);
  assign prod_ext_c = WIDTH'(prod_c);
  assign accept_c   = (state == S_ACCUM) && in_valid;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded handshake/status outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    act_ready = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && (cnt == LAST_CNT)) state_nxt = S_BIAS;
      end
      S_BIAS: begin
        state_nxt = S_ACT;
      end
      S_ACT: begin
        act_ready = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Accumulator, pair counter and result latch; sums wrap modulo 2^WIDTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_out <= '0;
      cnt     <= '0;
      result  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc_out <= '0;
            cnt     <= '0;
          end
        end
        S_ACCUM: begin
          if (accept_c) begin
            acc_out <= acc_out + prod_ext_c;
            cnt     <= cnt + CNT_W'(1);
          end
        end
        S_BIAS: begin
          acc_out <= acc_out + bias;
        end
        S_ACT: begin
          result <= act_in;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_sequencer.sv
module tb_neuron_sequencer;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NIN   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [7:0]       x_in;
  logic [7:0]       w_in;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] bias;
  logic [WIDTH-1:0] acc_out;
  logic             act_ready;
  logic [7:0]       act_in;
  logic [7:0]       result;
  logic             done;
  logic             busy;

  int compared = 0;
  int mismatched = 0;

  neuron_sequencer #(.WIDTH(WIDTH), .NUM_INPUTS(NIN), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .w_in(w_in),
    .in_valid(in_valid), .in_ready(in_ready), .bias(bias), .acc_out(acc_out),
    .act_ready(act_ready), .act_in(act_in), .result(result), .done(done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Activation block: ReLU clamped to the signed 8-bit maximum
  always_comb begin
    if ($signed(acc_out) < 0)         act_in = 8'h00;
    else if ($signed(acc_out) > 127)  act_in = 8'h7F;
    else                              act_in = acc_out[7:0];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
      else begin
        mismatched++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // One evaluation; xs/ws hold pair i in byte i. Reports the edge count
  // (after the start edge) at which done rose, acc_out seen in ACT, result,
  // gap-cycle accumulator changes and done one cycle after it rose.
  task automatic do_eval(input logic [31:0] xs, input logic [31:0] ws,
                         input logic [31:0] b, input bit gaps, input bit hold,
                         output int dcyc, output logic [31:0] acc_act,
                         output logic [7:0] res, output int gap_bad,
                         output logic done_after);
    int idx;
    bit last_valid;
    bit gap_chk;
    logic [31:0] acc_before;
    dcyc = -1; acc_act = '0; res = '0; gap_bad = 0; done_after = 1'b1;
    idx = 0; last_valid = 1'b0;
    start = 1'b1;
    bias  = b;
    tick();
    if (!hold) start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      gap_chk = gaps && last_valid && in_ready;
      if (in_ready && idx < int'(NIN) && !gap_chk) begin
        in_valid = 1'b1;
        x_in = xs[idx*8 +: 8];
        w_in = ws[idx*8 +: 8];
      end else begin
        in_valid = 1'b0;
        x_in = 8'($urandom);
        w_in = 8'($urandom);
      end
      acc_before = acc_out;
      last_valid = in_valid && in_ready;
      tick();
      if (last_valid) idx++;
      else if (gap_chk && acc_out !== acc_before) gap_bad++;
      if (act_ready) acc_act = acc_out;
      if (done) begin
        dcyc = c;
        res  = result;
        tick();
        done_after = done;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  int          dcyc;
  logic [31:0] acc_act;
  logic [7:0]  res;
  int          gap_bad;
  logic        done_after;

  initial begin
    rst = 1'b1; start = 1'b0; x_in = '0; w_in = '0; in_valid = 1'b0; bias = '0;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_acc", acc_out, 32'd0);
    check("rst_result", 32'(result), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Sum 1+2+3+4
    do_eval(32'h04030201, 32'h01010101, 32'd0, 1'b0, 1'b0, dcyc, acc_act, res, gap_bad, done_after);
    check("sum_acc", acc_act, 32'd10);
    check("sum_result", 32'(res), 32'd10);
    check("sum_latency", 32'(dcyc), 32'd6);
    check("sum_done_pulse", 32'(done_after), 32'd0);
    tick();
    tick();
    check("sum_result_hold", 32'(result), 32'd10);
    check("sum_idle_busy", 32'(busy), 32'd0);

    // Negative: 4 * (-10)
    do_eval(32'hF6F6F6F6, 32'h01010101, 32'd0, 1'b0, 1'b0, dcyc, acc_act, res, gap_bad, done_after);
    check("neg_acc", acc_act, 32'hFFFFFFD8);
    check("neg_result", 32'(res), 32'd0);

    // Saturation: 4 * 100*100 + 5
    do_eval(32'h64646464, 32'h64646464, 32'd5, 1'b0, 1'b0, dcyc, acc_act, res, gap_bad, done_after);
    check("sat_acc", acc_act, 32'd40005);
    check("sat_result", 32'(res), 32'h7F);

    // Backpressure: alternate-cycle gaps
    do_eval(32'h04030201, 32'h01010101, 32'd0, 1'b1, 1'b0, dcyc, acc_act, res, gap_bad, done_after);
    check("bp_acc", acc_act, 32'd10);
    check("bp_result", 32'(res), 32'd10);
    check("bp_latency", 32'(dcyc), 32'd9);
    check("bp_gap_hold", 32'(gap_bad), 32'd0);

    // Reset after two handshakes
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1; x_in = 8'd1; w_in = 8'd1;
    tick();
    x_in = 8'd2;
    tick();
    in_valid = 1'b0;
    check("midop_acc", acc_out, 32'd3);
    check("midop_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midop_rst_in_ready", 32'(in_ready), 32'd0);
    check("midop_rst_busy", 32'(busy), 32'd0);
    check("midop_rst_result", 32'(result), 32'd0);
    check("midop_rst_acc", acc_out, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    do_eval(32'h04030201, 32'h01010101, 32'd0, 1'b0, 1'b0, dcyc, acc_act, res, gap_bad, done_after);
    check("fresh_result", 32'(res), 32'd10);
    check("fresh_latency", 32'(dcyc), 32'd6);

    // start held high throughout, bias -10
    do_eval(32'h04030201, 32'h01010101, 32'hFFFFFFF6, 1'b0, 1'b1, dcyc, acc_act, res, gap_bad, done_after);
    check("hold_acc", acc_act, 32'd0);
    check("hold_result", 32'(res), 32'd0);
    check("hold_latency", 32'(dcyc), 32'd6);
    check("hold_idle_after_done", 32'(busy), 32'd0);
    tick();
    check("hold_restart_busy", 32'(busy), 32'd1);
    check("hold_restart_in_ready", 32'(in_ready), 32'd1);
    start = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
